// File: rtl/des_pkg.sv
// Shared DES constants and reference functions for the serial round function f(R,K).
// Bit numbering: DES bit 1 is the MSB of each vector.
package des_pkg;

  localparam int E_TABLE [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_TABLE [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each ROM holds 64 nibbles, entry (row*16 + col) at the MSB end first.
  localparam logic [255:0] S1_ROM = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  localparam logic [255:0] S2_ROM = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  localparam logic [255:0] S3_ROM = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  localparam logic [255:0] S4_ROM = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  localparam logic [255:0] S5_ROM = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  localparam logic [255:0] S6_ROM = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  localparam logic [255:0] S7_ROM = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  localparam logic [255:0] S8_ROM = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

  typedef enum logic [1:0] {IDLE, SUB, DONE} des_state_t;

  function automatic logic [47:0] des_expand(input logic [31:0] r);
    logic [47:0] e;
    e = '0;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_TABLE[i]];
    return e;
  endfunction

  function automatic logic [31:0] des_perm_p(input logic [31:0] s);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_TABLE[i]];
    return p;
  endfunction

  // Outer address bits pick the row, inner four bits the column.
  function automatic logic [3:0] des_sbox(input logic [2:0] j, input logic [5:0] a);
    logic [255:0] rom;
    logic [5:0]   ent;
    case (j)
      3'd0:    rom = S1_ROM;
      3'd1:    rom = S2_ROM;
      3'd2:    rom = S3_ROM;
      3'd3:    rom = S4_ROM;
      3'd4:    rom = S5_ROM;
      3'd5:    rom = S6_ROM;
      3'd6:    rom = S7_ROM;
      default: rom = S8_ROM;
    endcase
    ent = {a[5], a[0], a[4:1]};
    return rom[8'd255 - {ent, 2'b00} -: 4];
  endfunction

  function automatic logic [31:0] des_s_layer(input logic [47:0] x);
    logic [31:0] s;
    s = '0;
    for (int j = 0; j < 8; j++) s[31-4*j -: 4] = des_sbox(3'(j), x[47-6*j -: 6]);
    return s;
  endfunction

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    return des_perm_p(des_s_layer(des_expand(r) ^ k));
  endfunction

endpackage

// File: rtl/des_f_serial_if.sv
// Valid/ready operand and result bundle for the serial DES round function.
interface des_f_serial_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] r_in;
  logic [47:0] subkey;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f_out;
  logic [31:0] s_raw;

  modport master (
    output in_valid, r_in, subkey, out_ready,
    input  in_ready, out_valid, f_out, s_raw
  );

  modport slave (
    input  in_valid, r_in, subkey, out_ready,
    output in_ready, out_valid, f_out, s_raw
  );
endinterface

// File: rtl/des_sbox_bank.sv
// One S-box lane: selects S1..S8 by index and looks up the 6-bit address.
module des_sbox_bank
  import des_pkg::*;
(
  input  logic [2:0] idx,
  input  logic [5:0] addr,
  output logic [3:0] dout
);

  always_comb dout = des_sbox(idx, addr);

endmodule

// File: rtl/des_f_serial.sv
// DES round function f(R,K) with the eight S-boxes time-multiplexed over LANES lanes.
// Operands are registered on accept; results are held until the consumer takes them.
module des_f_serial
  import des_pkg::*;
#(
  parameter int LANES = 1
)
(
  input  logic          clk,
  input  logic          rst_n,
  des_f_serial_if.slave bus
);

  localparam logic [2:0] STEP     = 3'(LANES);
  localparam logic [2:0] LAST_IDX = 3'(8 - LANES);

  des_state_t  state, state_next;
  logic [47:0] x_q;
  logic [31:0] acc, acc_next;
  logic [31:0] f_q, s_q;
  logic [2:0]  idx;
  logic        out_valid_q;
  logic        accept, handoff, last;

  logic [2:0]  lane_idx  [LANES];
  logic [5:0]  lane_addr [LANES];
  logic [3:0]  lane_dout [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l]  = idx + 3'(l);
    assign lane_addr[l] = x_q[6'd47 - 6'(lane_idx[l]) * 6'd6 -: 6];
    des_sbox_bank u_sbox (.idx(lane_idx[l]), .addr(lane_addr[l]), .dout(lane_dout[l]));
  end

  always_comb begin
    acc_next = acc;
    for (int l = 0; l < LANES; l++) acc_next[5'd31 - {lane_idx[l], 2'b00} -: 4] = lane_dout[l];
  end

  assign last    = (idx == LAST_IDX);
  assign accept  = bus.in_valid & bus.in_ready;
  assign handoff = (state == DONE) & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // DONE re-arms on the handoff edge so a waiting operand pair is not stalled a cycle.
  always_comb begin
    state_next   = state;
    bus.in_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = SUB;
      end
      SUB: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        bus.in_ready = bus.out_ready;
        if (bus.out_ready) state_next = bus.in_valid ? SUB : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      acc         <= '0;
      idx         <= '0;
      f_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        x_q <= des_expand(bus.r_in) ^ bus.subkey;
        idx <= '0;
        acc <= '0;
      end else if (state == SUB) begin
        acc <= acc_next;
        if (last) begin
          f_q         <= des_perm_p(acc_next);
          s_q         <= acc_next;
          out_valid_q <= 1'b1;
          idx         <= '0;
        end else begin
          idx <= idx + STEP;
        end
      end
      if (handoff) out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.f_out     = f_q;
  assign bus.s_raw     = s_q;

endmodule
